id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX operand forwarding; sits directly upstream of the ALU.
//  Latches decoded control, operands and exception tags each cycle, with stall (hold) and flush (bubble).
//  Resolves RAW hazards by forwarding from MEM/WB and drives ALU op, f_op, A and B.
//  Carries exception state from decode into EX so that precise traps can be taken downstream.
// PARAMETERS
//  XLEN      32  datapath width
//  CAUSE_W   4   exception cause width
// PORTS
//  clk            in   1        clock; all state updates on rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  stall_i        in   1        hold ID/EX contents (EX not advancing)
//  flush_i        in   1        replace ID/EX contents with a bubble (branch/trap redirect)
//  id_valid       in   1        decode slot holds a real instruction
//  id_pc          in   XLEN     instruction PC
//  id_rs1_addr    in   5        source register 1 index
//  id_rs2_addr    in   5        source register 2 index
//  id_rs1_data    in   XLEN     register-file read data, rs1
//  id_rs2_data    in   XLEN     register-file read data, rs2
//  id_imm         in   XLEN     sign-extended immediate
//  id_rd_addr     in   5        destination register index
//  id_reg_we      in   1        instruction writes rd
//  id_alu_op      in   4        ALU operation code (ALU_* encodings)
//  id_f_op        in   3        branch compare code (F_* encodings; F_* none for non-branch)
//  id_a_sel       in   1        0: A = rs1, 1: A = pc
//  id_b_sel       in   1        0: B = rs2, 1: B = imm
//  id_exc_valid   in   1        decode raised an exception
//  id_exc_cause   in   CAUSE_W  exception cause code
//  mem_fwd_we/rd/data   in 1/5/XLEN  MEM-stage result available for forwarding
//  wb_fwd_we/rd/data    in 1/5/XLEN  WB-stage result available for forwarding
//  ex_valid       out  1        EX slot valid
//  ex_pc          out  XLEN     registered PC
//  ex_alu_op      out  4        to ALU op
//  ex_f_op        out  3        to ALU f_op
//  ex_alu_a       out  XLEN     to ALU A (forwarded, after a_sel mux)
//  ex_alu_b       out  XLEN     to ALU B (forwarded, after b_sel mux)
//  ex_store_data  out  XLEN     forwarded rs2 (store data), independent of b_sel
//  ex_rd_addr     out  5        destination register index
//  ex_reg_we      out  1        write enable; gated by valid and exception
//  ex_exc_valid   out  1        exception pending in EX
//  ex_exc_cause   out  CAUSE_W  exception cause
// BEHAVIOUR
//  - Reset (rst_n=0, async): every register is 0. ex_valid, ex_reg_we and ex_exc_valid are 0.
//    ex_alu_op is 0 and ex_f_op is 0, so the ALU computes C=0 and f=0.
//  - Update priority on each edge: reset > flush_i > stall_i > load.
//  - Flush: load a bubble (all registered fields 0), even if stall_i=1 in the same cycle.
//  - Stall: hold all fields, except the rs1/rs2 data registers.
//    Those capture their own forwarded value every stalled cycle, so a producer retiring
//    during the stall is not lost.
//  - Load: capture all id_* fields; latency is 1 cycle ID->EX.
//    ex_valid <= id_valid.
//    ex_reg_we <= id_valid & id_reg_we & ~id_exc_valid.
//    ex_exc_valid <= id_valid & id_exc_valid.
//  - Forwarding (combinational on registered rs_addr/rs_data), applied per source:
//    * if mem_fwd_we and mem_fwd_rd == rs and rs != 0, use mem_fwd_data;
//    * else if wb_fwd_we and wb_fwd_rd == rs and rs != 0, use wb_fwd_data;
//    * else use the registered data.
//    MEM wins over WB. x0 is never forwarded, so it always reads 0 from the register file.
//  - ex_alu_a = a_sel ? ex_pc : fwd_rs1.  ex_alu_b = b_sel ? imm : fwd_rs2.  ex_store_data = fwd_rs2.
//  - Bubbles (ex_valid=0) have no architectural effect: reg_we=0, exc_valid=0.
//  - Reset asserted mid-stall or mid-flush clears immediately; the first edge after release performs a normal load.
// TESTING
//  1 Reset: hold rst_n=0 with id_* nonzero -> all outputs 0. Release -> next edge loads id_*.
//  2 Forward priority: EX needs rs1=x5; MEM rd=5 data=0x11; WB rd=5 data=0x22 -> ex_alu_a=0x11.
//    Drop mem_fwd_we -> ex_alu_a=0x22.
//  3 x0 guard: rs1=0, mem_fwd_we=1, mem_fwd_rd=0, data=0xDEAD -> ex_alu_a=0.
//  4 Stall refresh: stall 2 cycles, WB writes x7=0x1234 in cycle 1, then wb_fwd_we=0 -> after stall, rs1=x7 gives ex_alu_a=0x1234.
//  5 Flush vs stall: flush_i=1 and stall_i=1 together, valid ADD loaded -> next cycle ex_valid=0, ex_reg_we=0, ex_alu_op=0.
//  6 Exception: id_valid=1, id_exc_valid=1, cause=2, id_reg_we=1 -> ex_exc_valid=1, ex_exc_cause=2, ex_reg_we=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and MEM/WB operand forwarding.
// Drives ALU operands, op codes, store data and exception state into EX.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1_addr,
    input  logic [4:0]         id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_rd_addr,
    input  logic               id_reg_we,
    input  logic [3:0]         id_alu_op,
    input  logic [2:0]         id_f_op,
    input  logic               id_a_sel,
    input  logic               id_b_sel,
    input  logic               id_exc_valid,
    input  logic [CAUSE_W-1:0] id_exc_cause,
    input  logic               mem_fwd_we,
    input  logic [4:0]         mem_fwd_rd,
    input  logic [XLEN-1:0]    mem_fwd_data,
    input  logic               wb_fwd_we,
    input  logic [4:0]         wb_fwd_rd,
    input  logic [XLEN-1:0]    wb_fwd_data,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [3:0]         ex_alu_op,
    output logic [2:0]         ex_f_op,
    output logic [XLEN-1:0]    ex_alu_a,
    output logic [XLEN-1:0]    ex_alu_b,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [4:0]         ex_rd_addr,
    output logic               ex_reg_we,
    output logic               ex_exc_valid,
    output logic [CAUSE_W-1:0] ex_exc_cause
);

    logic               valid_reg;
    logic [XLEN-1:0]    pc_reg;
    logic [XLEN-1:0]    imm_reg;
    logic [4:0]         rd_addr_reg;
    logic               reg_we_reg;
    logic [3:0]         alu_op_reg;
    logic [2:0]         f_op_reg;
    logic               a_sel_reg;
    logic               b_sel_reg;
    logic               exc_valid_reg;
    logic [CAUSE_W-1:0] exc_cause_reg;

    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;

    // Per-source operand register and forwarding mux (gi=0: rs1, gi=1: rs2)
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [4:0]      id_addr;
            logic [XLEN-1:0] id_data;
            logic [4:0]      addr_reg;
            logic [XLEN-1:0] data_reg;
            logic [XLEN-1:0] fwd_data;

            assign id_addr = (gi == 0) ? id_rs1_addr : id_rs2_addr;
            assign id_data = (gi == 0) ? id_rs1_data : id_rs2_data;

            // MEM beats WB; x0 is never forwarded
            always_comb begin
                fwd_data = data_reg;
                if (mem_fwd_we && (mem_fwd_rd == addr_reg) && (addr_reg != 5'd0))
                    fwd_data = mem_fwd_data;
                else if (wb_fwd_we && (wb_fwd_rd == addr_reg) && (addr_reg != 5'd0))
                    fwd_data = wb_fwd_data;
            end

            // While stalled the data register keeps absorbing forwarded results
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg <= '0;
                    data_reg <= '0;
                end else if (flush_i) begin
                    addr_reg <= '0;
                    data_reg <= '0;
                end else if (stall_i) begin
                    data_reg <= fwd_data;
                end else begin
                    addr_reg <= id_addr;
                    data_reg <= id_data;
                end
            end
        end
    endgenerate

    assign fwd_rs1 = g_src[0].fwd_data;
    assign fwd_rs2 = g_src[1].fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rd_addr_reg   <= '0;
            reg_we_reg    <= 1'b0;
            alu_op_reg    <= '0;
            f_op_reg      <= '0;
            a_sel_reg     <= 1'b0;
            b_sel_reg     <= 1'b0;
            exc_valid_reg <= 1'b0;
            exc_cause_reg <= '0;
        end else if (flush_i) begin
            valid_reg     <= 1'b0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rd_addr_reg   <= '0;
            reg_we_reg    <= 1'b0;
            alu_op_reg    <= '0;
            f_op_reg      <= '0;
            a_sel_reg     <= 1'b0;
            b_sel_reg     <= 1'b0;
            exc_valid_reg <= 1'b0;
            exc_cause_reg <= '0;
        end else if (!stall_i) begin
            valid_reg     <= id_valid;
            pc_reg        <= id_pc;
            imm_reg       <= id_imm;
            rd_addr_reg   <= id_rd_addr;
            reg_we_reg    <= id_valid & id_reg_we & ~id_exc_valid;
            alu_op_reg    <= id_alu_op;
            f_op_reg      <= id_f_op;
            a_sel_reg     <= id_a_sel;
            b_sel_reg     <= id_b_sel;
            exc_valid_reg <= id_valid & id_exc_valid;
            exc_cause_reg <= id_exc_cause;
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_pc         = pc_reg;
    assign ex_alu_op     = alu_op_reg;
    assign ex_f_op       = f_op_reg;
    assign ex_alu_a      = a_sel_reg ? pc_reg : fwd_rs1;
    assign ex_alu_b      = b_sel_reg ? imm_reg : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_rd_addr    = rd_addr_reg;
    assign ex_reg_we     = reg_we_reg;
    assign ex_exc_valid  = exc_valid_reg;
    assign ex_exc_cause  = exc_cause_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, x0 guard, stall refresh,
// flush-over-stall, exception tagging and async reset during stall.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_reg_we, id_a_sel, id_b_sel, id_exc_valid;
    logic [3:0]  id_alu_op;
    logic [2:0]  id_f_op;
    logic [3:0]  id_exc_cause;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_reg_we, ex_exc_valid;
    logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
    logic [3:0]  ex_alu_op, ex_exc_cause;
    logic [2:0]  ex_f_op;
    logic [4:0]  ex_rd_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rd_addr(id_rd_addr), .id_reg_we(id_reg_we),
        .id_alu_op(id_alu_op), .id_f_op(id_f_op),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_exc_valid(id_exc_valid), .id_exc_cause(id_exc_cause),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_op(ex_alu_op), .ex_f_op(ex_f_op),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we),
        .ex_exc_valid(ex_exc_valid), .ex_exc_cause(ex_exc_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_id(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] rd,
                           input logic we, input logic [3:0] op, input logic [2:0] fop,
                           input logic asel, input logic bsel,
                           input logic exc, input logic [3:0] cause);
        id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2; id_imm = imm; id_rd_addr = rd;
        id_reg_we = we; id_alu_op = op; id_f_op = fop; id_a_sel = asel;
        id_b_sel = bsel; id_exc_valid = exc; id_exc_cause = cause;
    endtask

    task automatic no_fwd();
        mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h0;
        wb_fwd_we  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h0;
    endtask

    initial begin
        // 1: reset with nonzero decode inputs
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        no_fwd();
        load_id(1'b1, 32'h100, 5'd3, 32'hAAAA, 5'd4, 32'hBBBB, 32'h40, 5'd9,
                1'b1, 4'd1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0);
        step(); step();
        $display("step reset-held");
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_alu_a", ex_alu_a, 32'd0);
        chk("rst_alu_b", ex_alu_b, 32'd0);
        chk("rst_store", ex_store_data, 32'd0);
        chk("rst_reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("rst_alu_op", {28'd0, ex_alu_op}, 32'd0);
        chk("rst_f_op", {29'd0, ex_f_op}, 32'd0);
        rst_n = 1'b1;
        step();
        $display("step first-load");
        chk("ld_valid", {31'd0, ex_valid}, 32'd1);
        chk("ld_pc", ex_pc, 32'h100);
        chk("ld_alu_a", ex_alu_a, 32'hAAAA);
        chk("ld_alu_b_imm", ex_alu_b, 32'h40);
        chk("ld_store", ex_store_data, 32'hBBBB);
        chk("ld_rd", {27'd0, ex_rd_addr}, 32'd9);
        chk("ld_reg_we", {31'd0, ex_reg_we}, 32'd1);
        chk("ld_alu_op", {28'd0, ex_alu_op}, 32'd1);
        chk("ld_f_op", {29'd0, ex_f_op}, 32'd2);

        // 2: forwarding priority, rs1=rs2=x5
        load_id(1'b1, 32'h200, 5'd5, 32'h99, 5'd5, 32'h99, 32'h0, 5'd1,
                1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h11;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 32'h22;
        #1;
        $display("step fwd-mem-wins");
        chk("fwd_mem_a", ex_alu_a, 32'h11);
        chk("fwd_mem_b", ex_alu_b, 32'h11);
        mem_fwd_we = 1'b0;
        #1;
        $display("step fwd-wb");
        chk("fwd_wb_a", ex_alu_a, 32'h22);
        chk("fwd_wb_store", ex_store_data, 32'h22);
        wb_fwd_we = 1'b0;
        #1;
        chk("fwd_none_a", ex_alu_a, 32'h99);

        // a_sel=1 selects PC regardless of forwarding
        load_id(1'b1, 32'h300, 5'd5, 32'h99, 5'd6, 32'h66, 32'h0, 5'd1,
                1'b1, 4'd2, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h11;
        step();
        $display("step a-sel-pc");
        chk("asel_pc", ex_alu_a, 32'h300);
        chk("bsel_rs2", ex_alu_b, 32'h66);
        no_fwd();

        // 3: x0 guard
        load_id(1'b1, 32'h400, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd2,
                1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hBEEF;
        #1;
        $display("step x0-guard");
        chk("x0_a", ex_alu_a, 32'h0);
        chk("x0_store", ex_store_data, 32'h0);
        no_fwd();

        // 4: stall refresh of rs1 data from WB
        load_id(1'b1, 32'h500, 5'd7, 32'h5, 5'd0, 32'h0, 32'h0, 5'd3,
                1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        stall_i = 1'b1;
        load_id(1'b1, 32'h999, 5'd8, 32'hFFFF, 5'd8, 32'hFFFF, 32'h7, 5'd8,
                1'b1, 4'd3, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0);
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h1234;
        step();
        wb_fwd_we = 1'b0;
        step();
        stall_i = 1'b0;
        #1;
        $display("step stall-refresh");
        chk("stall_a", ex_alu_a, 32'h1234);
        chk("stall_pc_hold", ex_pc, 32'h500);
        chk("stall_op_hold", {28'd0, ex_alu_op}, 32'd1);
        step();
        chk("post_stall_pc", ex_pc, 32'h999);

        // 5: flush beats stall
        load_id(1'b1, 32'h600, 5'd1, 32'h10, 5'd2, 32'h20, 32'h0, 5'd4,
                1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        flush_i = 1'b1; stall_i = 1'b1;
        step();
        flush_i = 1'b0; stall_i = 1'b0;
        $display("step flush-over-stall");
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("flush_alu_op", {28'd0, ex_alu_op}, 32'd0);
        chk("flush_alu_a", ex_alu_a, 32'd0);

        // 6: exception suppresses write enable
        load_id(1'b1, 32'h700, 5'd1, 32'h10, 5'd2, 32'h20, 32'h0, 5'd4,
                1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 1'b1, 4'd2);
        step();
        $display("step exception");
        chk("exc_valid", {31'd0, ex_exc_valid}, 32'd1);
        chk("exc_cause", {28'd0, ex_exc_cause}, 32'd2);
        chk("exc_reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("exc_ex_valid", {31'd0, ex_valid}, 32'd1);

        // bubble carrying stray exception/we bits has no effect
        load_id(1'b0, 32'h800, 5'd1, 32'h10, 5'd2, 32'h20, 32'h0, 5'd4,
                1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 1'b1, 4'd3);
        step();
        $display("step bubble");
        chk("bub_exc", {31'd0, ex_exc_valid}, 32'd0);
        chk("bub_reg_we", {31'd0, ex_reg_we}, 32'd0);

        // async reset during stall clears immediately; release reloads
        load_id(1'b1, 32'hA00, 5'd1, 32'h10, 5'd2, 32'h20, 32'h0, 5'd4,
                1'b1, 4'd5, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        $display("step async-reset-mid-stall");
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        step();
        rst_n = 1'b1; stall_i = 1'b0;
        step();
        $display("step reload-after-reset");
        chk("rel_pc", ex_pc, 32'hA00);
        chk("rel_reg_we", {31'd0, ex_reg_we}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
